// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse train generator.
// Contents: per-channel state enum, configuration address map and the
// values the configuration registers take after reset.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } chan_state_e;

    // Configuration address map (5..7 are reserved and ignored)
    localparam logic [2:0] ADDR_DELAY  = 3'd0;
    localparam logic [2:0] ADDR_PERIOD = 3'd1;
    localparam logic [2:0] ADDR_WIDTH  = 3'd2;
    localparam logic [2:0] ADDR_COUNT  = 3'd3;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;

    // Bit position of INVERT inside the CTRL register
    localparam int CTRL_INVERT_BIT = 0;

    // Configuration register values after reset
    localparam int   RST_DELAY  = 0;
    localparam int   RST_PERIOD = 2;
    localparam int   RST_WIDTH  = 1;
    localparam int   RST_COUNT  = 0;
    localparam logic RST_INVERT = 1'b0;

endpackage

// File: rtl/pulse_chan.sv
// One pulse generator channel.
// Holds the channel's configuration registers, the working (shadow) copy
// used by the running burst, the phase/period counters and the FSM
// IDLE -> DELAY -> HIGH <-> LOW -> IDLE.
// Ports:
//   Clk      rising-edge clock
//   Rst      synchronous active-high reset
//   cfg_we   write strobe already qualified for this channel
//   cfg_addr register select (0 DELAY, 1 PERIOD, 2 WIDTH, 3 COUNT, 4 CTRL)
//   cfg_data write data
//   start    start / restart request
//   stop     abort request (wins over start)
//   out      registered pulse output (raw level XOR INVERT)
//   busy     registered "channel not idle", aligned with out
//   done     one-cycle pulse on the final output cycle of a COUNT-limited burst
module pulse_chan #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    input  logic             start,
    input  logic             stop,
    output logic             out,
    output logic             busy,
    output logic             done
);
    import pulse_gen_pkg::*;

    localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

    // A zero period behaves as a one-cycle period
    function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] period);
        eff_period = (period == ZERO) ? ONE : period;
    endfunction

    // High time can never exceed the period it lives in
    function automatic logic [CNT_W-1:0] eff_width(input logic [CNT_W-1:0] width,
                                                  input logic [CNT_W-1:0] period);
        eff_width = (width > period) ? period : width;
    endfunction

    // Completed-period counter saturates instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        sat_inc = (value == ALL_ONES) ? value : value + ONE;
    endfunction

    // Configuration registers
    logic [CNT_W-1:0] cfg_delay_r;
    logic [CNT_W-1:0] cfg_period_r;
    logic [CNT_W-1:0] cfg_width_r;
    logic [CNT_W-1:0] cfg_count_r;
    logic             cfg_invert_r;

    // Working copy used by the running burst
    logic [CNT_W-1:0] sh_delay_r;
    logic [CNT_W-1:0] sh_period_r;
    logic [CNT_W-1:0] sh_width_r;
    logic [CNT_W-1:0] sh_count_r;

    chan_state_e      state_r;
    chan_state_e      state_s;
    logic [CNT_W-1:0] cnt_r;      // cycles spent in DELAY, or position inside the period
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] pulses_r;   // periods completed in this burst
    logic [CNT_W-1:0] pulses_s;
    logic             load_s;     // refresh working copy from configuration
    logic             done_s;

    logic [CNT_W-1:0] cur_pc_s;
    logic [CNT_W-1:0] cur_wc_s;
    logic [CNT_W-1:0] new_pc_s;
    logic [CNT_W-1:0] new_wc_s;
    logic             period_end_s;
    logic             last_period_s;
    logic             raw_s;

    logic             out_r;
    logic             busy_r;
    logic             done_r;

    // Current-period geometry comes from the working copy; the geometry of a
    // period about to begin comes straight from the configuration registers.
    assign cur_pc_s      = eff_period(sh_period_r);
    assign cur_wc_s      = eff_width(sh_width_r, cur_pc_s);
    assign new_pc_s      = eff_period(cfg_period_r);
    assign new_wc_s      = eff_width(cfg_width_r, new_pc_s);
    assign period_end_s  = ((state_r == HIGH) || (state_r == LOW)) && (cnt_r == cur_pc_s - ONE);
    assign last_period_s = period_end_s && (sh_count_r != ZERO) && (pulses_r == sh_count_r - ONE);
    assign raw_s         = (state_r == HIGH);

    // Next-state logic: stop beats start, start beats normal sequencing
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        pulses_s = pulses_r;
        load_s   = 1'b0;
        done_s   = 1'b0;
        if (stop) begin
            state_s = IDLE;
            cnt_s   = ZERO;
        end else if (start) begin
            load_s   = 1'b1;
            cnt_s    = ZERO;
            pulses_s = ZERO;
            if (cfg_delay_r != ZERO) begin
                state_s = DELAY;
            end else begin
                state_s = (new_wc_s != ZERO) ? HIGH : LOW;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                    cnt_s   = ZERO;
                end
                DELAY: begin
                    if (cnt_r == sh_delay_r - ONE) begin
                        cnt_s   = ZERO;
                        state_s = (cur_wc_s != ZERO) ? HIGH : LOW;
                    end else begin
                        cnt_s = cnt_r + ONE;
                    end
                end
                HIGH, LOW: begin
                    if (period_end_s) begin
                        pulses_s = sat_inc(pulses_r);
                        cnt_s    = ZERO;
                        if (last_period_s) begin
                            state_s = IDLE;
                            done_s  = 1'b1;
                        end else begin
                            // Period boundary: pick up any configuration written meanwhile
                            load_s  = 1'b1;
                            state_s = (new_wc_s != ZERO) ? HIGH : LOW;
                        end
                    end else begin
                        cnt_s   = cnt_r + ONE;
                        state_s = ((cnt_r + ONE) < cur_wc_s) ? HIGH : LOW;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = ZERO;
                end
            endcase
        end
    end

    // Configuration register writes; reserved addresses are dropped
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cfg_delay_r  <= CNT_W'(RST_DELAY);
            cfg_period_r <= CNT_W'(RST_PERIOD);
            cfg_width_r  <= CNT_W'(RST_WIDTH);
            cfg_count_r  <= CNT_W'(RST_COUNT);
            cfg_invert_r <= RST_INVERT;
        end else if (cfg_we) begin
            case (cfg_addr)
                ADDR_DELAY:  cfg_delay_r  <= cfg_data;
                ADDR_PERIOD: cfg_period_r <= cfg_data;
                ADDR_WIDTH:  cfg_width_r  <= cfg_data;
                ADDR_COUNT:  cfg_count_r  <= cfg_data;
                ADDR_CTRL:   cfg_invert_r <= cfg_data[CTRL_INVERT_BIT];
                default: begin
                end
            endcase
        end
    end

    // Working copy refresh on start and at period boundaries
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sh_delay_r  <= CNT_W'(RST_DELAY);
            sh_period_r <= CNT_W'(RST_PERIOD);
            sh_width_r  <= CNT_W'(RST_WIDTH);
            sh_count_r  <= CNT_W'(RST_COUNT);
        end else if (load_s) begin
            sh_delay_r  <= cfg_delay_r;
            sh_period_r <= cfg_period_r;
            sh_width_r  <= cfg_width_r;
            sh_count_r  <= cfg_count_r;
        end
    end

    // FSM state and counters
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r  <= IDLE;
            cnt_r    <= ZERO;
            pulses_r <= ZERO;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            pulses_r <= pulses_s;
        end
    end

    // Output stage: all three outputs lag the FSM by one cycle so they stay
    // mutually aligned; INVERT is taken from the live register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            out_r  <= raw_s ^ cfg_invert_r;
            busy_r <= (state_r != IDLE);
            done_r <= done_s;
        end
    end

    assign out  = out_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: rtl/pulse_train_gen.sv
// Multi-channel pulse train generator.
// CHANNELS independent pulse_chan instances; this level only decodes the
// shared configuration write port to the addressed channel.
// Ports:
//   Clk       rising-edge clock
//   Rst       synchronous active-high reset (config and FSMs)
//   Cfg_we    configuration write strobe
//   Cfg_ch    target channel; values >= CHANNELS are ignored
//   Cfg_addr  0 DELAY, 1 PERIOD, 2 WIDTH, 3 COUNT, 4 CTRL(bit0 INVERT), 5-7 reserved
//   Cfg_data  write data
//   Start     per-channel start/restart pulse
//   Stop      per-channel abort pulse
//   Out       registered pulse outputs
//   Busy      per-channel not-idle flag
//   Done      per-channel burst-complete pulse
module pulse_train_gen #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 16,
    parameter int CH_W     = 4
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Cfg_we,
    input  logic [CH_W-1:0]     Cfg_ch,
    input  logic [2:0]          Cfg_addr,
    input  logic [CNT_W-1:0]    Cfg_data,
    input  logic [CHANNELS-1:0] Start,
    input  logic [CHANNELS-1:0] Stop,
    output logic [CHANNELS-1:0] Out,
    output logic [CHANNELS-1:0] Busy,
    output logic [CHANNELS-1:0] Done
);
    import pulse_gen_pkg::*;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic we_s;

        // Out-of-range channel numbers simply match no instance
        assign we_s = Cfg_we && (Cfg_ch == CH_W'(i));

        pulse_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .Clk      (Clk),
            .Rst      (Rst),
            .cfg_we   (we_s),
            .cfg_addr (Cfg_addr),
            .cfg_data (Cfg_data),
            .start    (Start[i]),
            .stop     (Stop[i]),
            .out      (Out[i]),
            .busy     (Busy[i]),
            .done     (Done[i])
        );
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: directed scenarios with literal
// expectations plus a randomized phase, all cross-checked every cycle
// against a timeline model (cycles since start, period start offset).
module tb_pulse_train_gen;
    localparam int CHANNELS = 2;
    localparam int CNT_W    = 16;
    localparam int CH_W     = 4;

    logic                Clk = 1'b0;
    logic                Rst;
    logic                Cfg_we;
    logic [CH_W-1:0]     Cfg_ch;
    logic [2:0]          Cfg_addr;
    logic [CNT_W-1:0]    Cfg_data;
    logic [CHANNELS-1:0] Start;
    logic [CHANNELS-1:0] Stop;
    logic [CHANNELS-1:0] Out;
    logic [CHANNELS-1:0] Busy;
    logic [CHANNELS-1:0] Done;

    int errors = 0;
    int checks = 0;

    pulse_train_gen #(.CHANNELS(CHANNELS), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .Clk(Clk), .Rst(Rst), .Cfg_we(Cfg_we), .Cfg_ch(Cfg_ch), .Cfg_addr(Cfg_addr),
        .Cfg_data(Cfg_data), .Start(Start), .Stop(Stop), .Out(Out), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cfg_delay [CHANNELS];
    int m_cfg_period[CHANNELS];
    int m_cfg_width [CHANNELS];
    int m_cfg_count [CHANNELS];
    int m_cfg_inv   [CHANNELS];
    bit m_run       [CHANNELS];
    int m_elapsed   [CHANNELS];   // cycles since the start edge
    int m_delay     [CHANNELS];
    int m_pbeg      [CHANNELS];   // elapsed value at which the current period began
    int m_pc        [CHANNELS];
    int m_wc        [CHANNELS];
    int m_lim       [CHANNELS];
    int m_periods   [CHANNELS];
    logic [CHANNELS-1:0] exp_out, exp_busy, exp_done;
    bit mdl_valid = 1'b0;

    task automatic load_period(input int c);
        m_pc[c]  = (m_cfg_period[c] < 1) ? 1 : m_cfg_period[c];
        m_wc[c]  = (m_cfg_width[c] > m_pc[c]) ? m_pc[c] : m_cfg_width[c];
        m_lim[c] = m_cfg_count[c];
    endtask

    task automatic model_step();
        logic [CHANNELS-1:0] o, b, d;
        int pos;
        bit inp;
        for (int c = 0; c < CHANNELS; c++) begin
            inp  = m_run[c] && (m_elapsed[c] >= m_delay[c]);
            pos  = m_elapsed[c] - m_pbeg[c];
            o[c] = (inp && (pos < m_wc[c])) != (m_cfg_inv[c] != 0);
            b[c] = m_run[c];
            d[c] = inp && (pos == m_pc[c] - 1) && (m_lim[c] != 0) &&
                   (m_periods[c] + 1 == m_lim[c]) && !Start[c] && !Stop[c];
            if (Rst) begin
                o[c] = 1'b0; b[c] = 1'b0; d[c] = 1'b0;
                m_cfg_delay[c] = 0; m_cfg_period[c] = 2; m_cfg_width[c] = 1;
                m_cfg_count[c] = 0; m_cfg_inv[c] = 0;
                m_run[c] = 1'b0;
            end else begin
                if (Stop[c]) begin
                    m_run[c] = 1'b0;
                end else if (Start[c]) begin
                    m_run[c] = 1'b1; m_elapsed[c] = 0; m_periods[c] = 0;
                    m_delay[c] = m_cfg_delay[c]; m_pbeg[c] = m_cfg_delay[c];
                    load_period(c);
                end else if (m_run[c]) begin
                    if (inp && (pos == m_pc[c] - 1)) begin
                        m_periods[c]++;
                        if ((m_lim[c] != 0) && (m_periods[c] == m_lim[c])) begin
                            m_run[c] = 1'b0;
                        end else begin
                            load_period(c);
                            m_pbeg[c] = m_elapsed[c] + 1;
                        end
                    end
                    m_elapsed[c]++;
                end
                if (Cfg_we && (int'(Cfg_ch) == c)) begin
                    case (Cfg_addr)
                        3'd0: m_cfg_delay[c]  = int'(Cfg_data);
                        3'd1: m_cfg_period[c] = int'(Cfg_data);
                        3'd2: m_cfg_width[c]  = int'(Cfg_data);
                        3'd3: m_cfg_count[c]  = int'(Cfg_data);
                        3'd4: m_cfg_inv[c]    = int'(Cfg_data[0]);
                        default: ;
                    endcase
                end
            end
        end
        exp_out = o; exp_busy = b; exp_done = d;
        mdl_valid = 1'b1;
    endtask

    initial begin : model_proc
        forever begin
            @(posedge Clk);
            model_step();
        end
    end

    // Compare process: every cycle, away from the active edge
    initial begin : compare_proc
        forever begin
            @(negedge Clk);
            if (mdl_valid) begin
                check("mdl_out",  32'(Out),  32'(exp_out));
                check("mdl_busy", 32'(Busy), 32'(exp_busy));
                check("mdl_done", 32'(Done), 32'(exp_done));
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wr(input int ch, input int addr, input int data);
        Cfg_we = 1'b1; Cfg_ch = CH_W'(ch); Cfg_addr = 3'(addr); Cfg_data = CNT_W'(data);
        @(negedge Clk);
        Cfg_we = 1'b0;
    endtask

    task automatic start_ch(input logic [CHANNELS-1:0] mask);
        Start = mask;
        @(negedge Clk);
        Start = '0;
    endtask

    task automatic stop_ch(input logic [CHANNELS-1:0] mask);
        Stop = mask;
        @(negedge Clk);
        Stop = '0;
    endtask

    // Sample n cycles of one channel; bit k holds the k-th cycle after the call
    task automatic record(input int ch, input int n,
                          output logic [15:0] po, output logic [15:0] pb, output logic [15:0] pd);
        po = '0; pb = '0; pd = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge Clk);
            Cfg_we = 1'b0; Start = '0; Stop = '0;
            po[k] = Out[ch]; pb[k] = Busy[ch]; pd[k] = Done[ch];
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] po, pb, pd;
        int errs;
        Rst = 1'b1; Cfg_we = 1'b0; Cfg_ch = '0; Cfg_addr = '0; Cfg_data = '0;
        Start = '0; Stop = '0;
        tick(3);
        check("rst_out",  32'(Out),  32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        Rst = 1'b0;
        tick(1);

        // A: free running 95 high / 105 low
        wr(0, 1, 200); wr(0, 2, 95);
        start_ch(2'b01);
        errs = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge Clk);
            if (Out[0] !== (((k - 1) % 200) < 95)) errs++;
            if (Busy[0] !== 1'b1) errs++;
        end
        check("a_wave", errs, 0);
        stop_ch(2'b01);
        tick(1);
        check("a_stop_busy", 32'(Busy[0]), 32'd0);

        // B: delayed counted burst
        wr(0, 0, 3); wr(0, 1, 4); wr(0, 2, 2); wr(0, 3, 2);
        start_ch(2'b01);
        record(0, 12, po, pb, pd);
        check("b_out",  32'(po), 32'h198);
        check("b_busy", 32'(pb), 32'h7FF);
        check("b_done", 32'(pd), 32'h400);

        // C: width 0, width >= period, period 0
        wr(0, 0, 0); wr(0, 2, 0); wr(0, 3, 0);
        start_ch(2'b01);
        record(0, 12, po, pb, pd);
        check("c_w0_out",  32'(po), 32'h000);
        check("c_w0_busy", 32'(pb), 32'hFFF);
        stop_ch(2'b01);
        wr(0, 2, 10);
        start_ch(2'b01);
        record(0, 12, po, pb, pd);
        check("c_wide_out", 32'(po), 32'hFFF);
        stop_ch(2'b01);
        wr(0, 1, 0); wr(0, 2, 1); wr(0, 3, 3);
        start_ch(2'b01);
        record(0, 6, po, pb, pd);
        check("c_p0_out",  32'(po), 32'h07);
        check("c_p0_busy", 32'(pb), 32'h07);
        check("c_p0_done", 32'(pd), 32'h04);

        // D: inverted channel tracks the plain one
        wr(0, 1, 4); wr(0, 3, 0);
        wr(1, 1, 4); wr(1, 2, 1); wr(1, 4, 1);
        tick(2);
        check("d_idle_inv", 32'(Out), 32'h2);
        start_ch(2'b11);
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (Out[1] !== ~Out[0]) errs++;
        end
        check("d_inv_track", errs, 0);
        stop_ch(2'b11);

        // E: period rewrite mid-HIGH, then restart on the final cycle
        wr(0, 1, 4); wr(0, 2, 2);
        start_ch(2'b01);
        Cfg_we = 1'b1; Cfg_ch = 4'd0; Cfg_addr = 3'd1; Cfg_data = 16'd8;
        record(0, 12, po, pb, pd);
        check("e_rewrite_out", 32'(po), 32'h033);
        stop_ch(2'b01);
        wr(0, 1, 4); wr(0, 3, 2);
        start_ch(2'b01);
        tick(7);
        start_ch(2'b01);
        check("e_restart_no_done", 32'(Done[0]), 32'd0);
        record(0, 10, po, pb, pd);
        check("e_restart_done", 32'(pd), 32'h080);

        // F: stop and start together on the inverted channel
        start_ch(2'b10);
        tick(3);
        Start = 2'b10; Stop = 2'b10;
        @(negedge Clk);
        Start = '0; Stop = '0;
        tick(1);
        check("f_busy", 32'(Busy[1]), 32'd0);
        check("f_out",  32'(Out[1]),  32'd1);

        // G: reset mid-burst, then defaults (period 2, width 1)
        start_ch(2'b01);
        tick(3);
        Rst = 1'b1;
        @(negedge Clk);
        check("g_rst_out",  32'(Out),  32'd0);
        check("g_rst_busy", 32'(Busy), 32'd0);
        Rst = 1'b0;
        start_ch(2'b01);
        record(0, 6, po, pb, pd);
        check("g_default_out", 32'(po), 32'h15);
        check("g_ch1_out", 32'(Out[1]), 32'd0);

        // H: randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int a;
            a = $urandom_range(0, 7);
            Cfg_we   = ($urandom_range(0, 3) == 0);
            Cfg_ch   = CH_W'($urandom_range(0, 3));
            Cfg_addr = 3'(a);
            case (a)
                0: Cfg_data = CNT_W'($urandom_range(0, 5));
                1: Cfg_data = CNT_W'($urandom_range(0, 10));
                2: Cfg_data = CNT_W'($urandom_range(0, 12));
                3: Cfg_data = CNT_W'($urandom_range(0, 4));
                4: Cfg_data = CNT_W'($urandom_range(0, 3));
                default: Cfg_data = CNT_W'($urandom);
            endcase
            for (int c = 0; c < CHANNELS; c++) begin
                Start[c] = ($urandom_range(0, 39) == 0);
                Stop[c]  = ($urandom_range(0, 79) == 0);
            end
            Rst = ($urandom_range(0, 499) == 0);
            @(negedge Clk);
        end
        Rst = 1'b0; Cfg_we = 1'b0; Start = '0; Stop = '0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
